// File: rtl/miriscv_lsu_pkg.sv
// Shared definitions for the load/store unit: access size codes, FSM states
// and the byte-enable patterns for each access width.
package miriscv_lsu_pkg;

    localparam logic [2:0] LDST_B  = 3'd0;
    localparam logic [2:0] LDST_H  = 3'd1;
    localparam logic [2:0] LDST_W  = 3'd2;
    localparam logic [2:0] LDST_BU = 3'd4;
    localparam logic [2:0] LDST_HU = 3'd5;

    typedef enum logic [1:0] {
        LSU_IDLE    = 2'd0,
        LSU_REQ     = 2'd1,
        LSU_WAIT_RV = 2'd2,
        LSU_DONE    = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/miriscv_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication and
// misalign/bad-size detection for a new request, plus load extraction.
module miriscv_lsu_align
    import miriscv_lsu_pkg::*;
(
    input  logic [2:0]  req_size_i,
    input  logic [1:0]  req_offs_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  req_be_o,
    output logic [31:0] req_wdata_o,
    output logic        req_err_o,
    input  logic [2:0]  rsp_size_i,
    input  logic [1:0]  rsp_offs_i,
    input  logic [31:0] rsp_rdata_i,
    output logic [31:0] rsp_data_o
);

    logic [7:0]  rsp_byte;
    logic [15:0] rsp_half;

    always_comb begin
        req_be_o    = '0;
        req_wdata_o = req_wdata_i;
        req_err_o   = 1'b0;
        case (req_size_i)
            LDST_B, LDST_BU: begin
                req_be_o    = BE_BYTE << req_offs_i;
                req_wdata_o = {4{req_wdata_i[7:0]}};
            end
            LDST_H, LDST_HU: begin
                req_be_o    = BE_HALF << {req_offs_i[1], 1'b0};
                req_wdata_o = {2{req_wdata_i[15:0]}};
                req_err_o   = req_offs_i[0];
            end
            LDST_W: begin
                req_be_o  = BE_WORD;
                req_err_o = |req_offs_i;
            end
            default: req_err_o = 1'b1;
        endcase
    end

    always_comb begin
        case (rsp_offs_i)
            2'd0:    rsp_byte = rsp_rdata_i[7:0];
            2'd1:    rsp_byte = rsp_rdata_i[15:8];
            2'd2:    rsp_byte = rsp_rdata_i[23:16];
            default: rsp_byte = rsp_rdata_i[31:24];
        endcase
        rsp_half = rsp_offs_i[1] ? rsp_rdata_i[31:16] : rsp_rdata_i[15:0];

        case (rsp_size_i)
            LDST_B:  rsp_data_o = {{24{rsp_byte[7]}}, rsp_byte};
            LDST_BU: rsp_data_o = {24'd0, rsp_byte};
            LDST_H:  rsp_data_o = {{16{rsp_half[15]}}, rsp_half};
            LDST_HU: rsp_data_o = {16'd0, rsp_half};
            default: rsp_data_o = rsp_rdata_i;
        endcase
    end

endmodule

// File: rtl/miriscv_lsu.sv
// Load/store unit: latches a decoded access, runs the req/gnt/rvalid handshake
// with data memory while stalling the core, and returns extended load data.
module miriscv_lsu
    import miriscv_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        arstn_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [2:0]  lsu_size_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_data_i,
    output logic [31:0] lsu_data_o,
    output logic        lsu_stall_req_o,
    output logic        lsu_err_o,
    output logic        data_req_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i
);

    lsu_state_e  state_q, state_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] cnt_q;

    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        req_err;
    logic [31:0] rsp_data;
    logic        timeout_hit;

    miriscv_lsu_align u_align (
        .req_size_i  (lsu_size_i),
        .req_offs_i  (lsu_addr_i[1:0]),
        .req_wdata_i (lsu_data_i),
        .req_be_o    (req_be),
        .req_wdata_o (req_wdata),
        .req_err_o   (req_err),
        .rsp_size_i  (size_q),
        .rsp_offs_i  (addr_q[1:0]),
        .rsp_rdata_i (data_rdata_i),
        .rsp_data_o  (rsp_data)
    );

    // >= rather than == so an access granted on the last budgeted cycle still
    // times out in WAIT_RV instead of waiting forever.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q >= 32'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) state_q <= LSU_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:    if (lsu_req_i) state_d = req_err ? LSU_DONE : LSU_REQ;
            LSU_REQ:     if (data_gnt_i) state_d = LSU_WAIT_RV;
                         else if (timeout_hit) state_d = LSU_DONE;
            LSU_WAIT_RV: if (data_rvalid_i || timeout_hit) state_d = LSU_DONE;
            default:     state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        data_req_o      = (state_q == LSU_REQ);
        lsu_stall_req_o = lsu_req_i && (state_q != LSU_DONE);
        lsu_err_o       = (state_q == LSU_DONE) && err_q;
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            we_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                LSU_IDLE: if (lsu_req_i) begin
                    we_q    <= lsu_we_i;
                    size_q  <= lsu_size_i;
                    addr_q  <= lsu_addr_i;
                    be_q    <= req_be;
                    wdata_q <= req_wdata;
                    err_q   <= req_err;
                    cnt_q   <= '0;
                end
                LSU_REQ: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (!data_gnt_i && timeout_hit) err_q <= 1'b1;
                end
                LSU_WAIT_RV: begin
                    cnt_q <= cnt_q + 32'd1;
                    if (data_rvalid_i) begin
                        if (!we_q) rdata_q <= rsp_data;
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end
                end
                default: err_q <= 1'b0;
            endcase
        end
    end

    assign lsu_data_o   = rdata_q;
    assign data_we_o    = we_q;
    assign data_be_o    = be_q;
    assign data_addr_o  = {addr_q[31:2], 2'b00};
    assign data_wdata_o = wdata_q;

endmodule
